dm_access_arbiter: RTL and testbench

- Shares the single-port 4 KB word data memory (1024 x 32, synchronous write, combinational read) between two requesters: the CPU load/store unit and the program/data loader port.
- Round-robin arbitration with a req/ack handshake.
- Adds byte-enable writes by sequencing read-modify-write on the word-only memory.
- Sits between the MEM pipeline stage / loader and the data memory instance.

---
 rtl/dm_arb_pkg.sv | 25 ++
 rtl/dm_byte_merge.sv | 24 ++
 rtl/dm_access_arbiter.sv | 162 ++++++++++++++++
 tb/tb_dm_access_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// -----------------------------------------------------------------------------
// dm_arb_pkg
// Shared types and constants for the data-memory access arbiter.
//   state_e : arbiter sequencing states
//   owner_e : which requester currently holds (or last held) the memory
//   BE_FULL / BE_NONE : byte-enable patterns that bypass read-modify-write
// -----------------------------------------------------------------------------
package dm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    MERGE  = 2'd2,
    DONE   = 2'd3
  } state_e;

  typedef enum logic {
    CPU = 1'b0,
    LDR = 1'b1
  } owner_e;

  localparam logic [3:0] BE_FULL = 4'hF;
  localparam logic [3:0] BE_NONE = 4'h0;

endpackage

// File: rtl/dm_byte_merge.sv
// -----------------------------------------------------------------------------
// dm_byte_merge
// Combinational byte-lane merge used for partial writes.
//   old_word_i    : word currently held in memory
//   new_word_i    : requester write data (lanes aligned to the word)
//   be_i          : byte enables, bit i selects byte i of new_word_i
//   merged_word_o : per-lane select of new (be=1) or old (be=0) byte
// -----------------------------------------------------------------------------
module dm_byte_merge #(
  parameter int DATA_W = 32,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic [DATA_W-1:0] old_word_i,
  input  logic [DATA_W-1:0] new_word_i,
  input  logic [BE_W-1:0]   be_i,
  output logic [DATA_W-1:0] merged_word_o
);

  for (genvar i = 0; i < BE_W; i++) begin : g_lane
    assign merged_word_o[8*i +: 8] = be_i[i] ? new_word_i[8*i +: 8]
                                             : old_word_i[8*i +: 8];
  end

endmodule

// File: rtl/dm_access_arbiter.sv
// -----------------------------------------------------------------------------
// dm_access_arbiter
// Shares a single-port word data memory between the CPU load/store unit and
// the loader port. Round-robin on ties, req/ack handshake, and byte-enable
// writes done as read-modify-write on the word-only memory.
//   clock, reset_n          : clock, asynchronous active-low reset
//   cpu_* / ldr_*           : requester ports (req held until the ack pulse;
//                             rdata valid on ack, held until the next read)
//   dm_mem_write            : memory write strobe
//   dm_address              : full byte address (memory decodes addr[11:2])
//   dm_data_in              : memory write data
//   dm_data_out             : combinational memory read data
// -----------------------------------------------------------------------------
module dm_access_arbiter
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [BE_W-1:0]   cpu_be,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [BE_W-1:0]   ldr_be,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_ack,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              dm_mem_write,
  output logic [ADDR_W-1:0] dm_address,
  output logic [DATA_W-1:0] dm_data_in,
  input  logic [DATA_W-1:0] dm_data_out
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_owner_q, last_owner_d;
  logic              we_q, we_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] merge_q, merge_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;
  logic [DATA_W-1:0] din_q;
  logic [DATA_W-1:0] merged_word;
  logic              grant_cpu;

  dm_byte_merge #(
    .DATA_W (DATA_W),
    .BE_W   (BE_W)
  ) u_merge (
    .old_word_i    (merge_q),
    .new_word_i    (wdata_q),
    .be_i          (be_q),
    .merged_word_o (merged_word)
  );

  // addr_q only changes at the grant edge, so between operations it still
  // holds the address last presented to memory.
  assign dm_address = addr_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign ldr_rdata  = ldr_rdata_q;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    be_d         = be_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    merge_d      = merge_q;
    cpu_rdata_d  = cpu_rdata_q;
    ldr_rdata_d  = ldr_rdata_q;
    grant_cpu    = 1'b0;
    dm_mem_write = 1'b0;
    dm_data_in   = din_q;
    cpu_ack      = 1'b0;
    ldr_ack      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cpu_req || ldr_req) begin
          // On a tie the requester that did not go last wins.
          grant_cpu = cpu_req && (!ldr_req || (last_owner_q == LDR));
          owner_d   = grant_cpu ? CPU : LDR;
          we_d      = grant_cpu ? cpu_we    : ldr_we;
          be_d      = grant_cpu ? cpu_be    : ldr_be;
          addr_d    = grant_cpu ? cpu_addr  : ldr_addr;
          wdata_d   = grant_cpu ? cpu_wdata : ldr_wdata;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        if (!we_q) begin
          if (owner_q == CPU) cpu_rdata_d = dm_data_out;
          else                ldr_rdata_d = dm_data_out;
          state_d = DONE;
        end else if (be_q == BE_FULL) begin
          dm_mem_write = 1'b1;
          dm_data_in   = wdata_q;
          state_d      = DONE;
        end else if (be_q == BE_NONE) begin
          state_d = DONE;
        end else begin
          merge_d = dm_data_out;
          state_d = MERGE;
        end
      end
      MERGE: begin
        dm_mem_write = 1'b1;
        dm_data_in   = merged_word;
        state_d      = DONE;
      end
      DONE: begin
        cpu_ack      = (owner_q == CPU);
        ldr_ack      = (owner_q == LDR);
        last_owner_d = owner_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      owner_q      <= CPU;
      last_owner_q <= LDR;
      we_q         <= 1'b0;
      be_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      merge_q      <= '0;
      cpu_rdata_q  <= '0;
      ldr_rdata_q  <= '0;
      din_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      be_q         <= be_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      merge_q      <= merge_d;
      cpu_rdata_q  <= cpu_rdata_d;
      ldr_rdata_q  <= ldr_rdata_d;
      din_q        <= dm_data_in;
    end
  end

endmodule

// File: tb/tb_dm_access_arbiter.sv
module tb_dm_access_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [3:0]  cpu_be = 4'h0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic        ldr_req = 1'b0, ldr_we = 1'b0;
  logic [3:0]  ldr_be = 4'h0;
  logic [31:0] ldr_addr = '0, ldr_wdata = '0;
  logic        ldr_ack;
  logic [31:0] ldr_rdata;
  logic        dm_mem_write;
  logic [31:0] dm_address, dm_data_in, dm_data_out;

  dm_access_arbiter #(.ADDR_W(32), .DATA_W(32), .BE_W(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_be(ldr_be), .ldr_addr(ldr_addr),
    .ldr_wdata(ldr_wdata), .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
    .dm_mem_write(dm_mem_write), .dm_address(dm_address),
    .dm_data_in(dm_data_in), .dm_data_out(dm_data_out)
  );

  always #5 clock = ~clock;

  // ---------------- memory attached to the DUT ----------------
  function automatic logic [31:0] pat(int i);
    if (i == 4) return 32'hDEADBEEF;
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
  endfunction

  logic [31:0] mem [0:1023];
  logic        mem_init_done = 1'b0;
  int          wr_cnt = 0;
  assign dm_data_out = mem[dm_address[11:2]];

  always @(posedge clock) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
      mem_init_done <= 1'b1;
    end else if (dm_mem_write) begin
      mem[dm_address[11:2]] <= dm_data_in;
      wr_cnt <= wr_cnt + 1;
    end
  end

  // ---------------- reference model + scoreboard ----------------
  logic [31:0] ref_mem [0:1023];
  typedef struct { bit is_rd; logic [31:0] rdata; } exp_t;
  exp_t cpu_q[$];
  exp_t ldr_q[$];
  int   ack_order[$];
  int   n_tests = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the expected response whenever an ack appears, and checks
  // that rdata never moves except on a read completion of that requester.
  logic [31:0] prev_cpu_rd = '0, prev_ldr_rd = '0;
  logic        prev_cpu_ack = 1'b0, prev_ldr_ack = 1'b0;

  always @(negedge clock) begin
    exp_t e;
    if (!reset_n) begin
      prev_cpu_rd  = '0;
      prev_ldr_rd  = '0;
      prev_cpu_ack = 1'b0;
      prev_ldr_ack = 1'b0;
    end else begin
      if (cpu_ack && ldr_ack) chk("both_ack", 32'(ldr_ack), 32'd0);
      if (cpu_ack) begin
        ack_order.push_back(0);
        chk("cpu_ack_pulse", 32'(prev_cpu_ack), 32'd0);
        if (cpu_q.size() == 0) chk("cpu_unexpected_ack", 32'd1, 32'd0);
        else begin
          e = cpu_q.pop_front();
          if (e.is_rd) chk("cpu_rdata", cpu_rdata, e.rdata);
          else         chk("cpu_rdata_hold_wr", cpu_rdata, prev_cpu_rd);
        end
      end else if (cpu_rdata !== prev_cpu_rd) chk("cpu_rdata_stable", cpu_rdata, prev_cpu_rd);
      if (ldr_ack) begin
        ack_order.push_back(1);
        chk("ldr_ack_pulse", 32'(prev_ldr_ack), 32'd0);
        if (ldr_q.size() == 0) chk("ldr_unexpected_ack", 32'd1, 32'd0);
        else begin
          e = ldr_q.pop_front();
          if (e.is_rd) chk("ldr_rdata", ldr_rdata, e.rdata);
          else         chk("ldr_rdata_hold_wr", ldr_rdata, prev_ldr_rd);
        end
      end else if (ldr_rdata !== prev_ldr_rd) chk("ldr_rdata_stable", ldr_rdata, prev_ldr_rd);
      prev_cpu_rd  = cpu_rdata;
      prev_ldr_rd  = ldr_rdata;
      prev_cpu_ack = cpu_ack;
      prev_ldr_ack = ldr_ack;
    end
  end

  // ---------------- driver ----------------
  function automatic logic get_ack(int who);
    return (who == 0) ? cpu_ack : ldr_ack;
  endfunction

  task automatic release_req(input int who);
    if (who == 0) cpu_req = 1'b0; else ldr_req = 1'b0;
  endtask

  // Called at a negedge. Leaves req high on return so the caller can chain a
  // back-to-back request or release. n = rising edges from issue to ack.
  task automatic do_op(input int who, input bit we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int exp_lat, input int max_lat, input int exp_wr);
    exp_t e;
    int   w, n, w0;
    bit   got;
    w = int'(addr[11:2]);
    e.is_rd = !we;
    e.rdata = ref_mem[w];
    if (we) for (int b = 0; b < 4; b++) if (be[b]) ref_mem[w][8*b +: 8] = wdata[8*b +: 8];
    if (who == 0) begin
      cpu_q.push_back(e);
      cpu_req = 1'b1; cpu_we = we; cpu_be = be; cpu_addr = addr; cpu_wdata = wdata;
    end else begin
      ldr_q.push_back(e);
      ldr_req = 1'b1; ldr_we = we; ldr_be = be; ldr_addr = addr; ldr_wdata = wdata;
    end
    w0 = wr_cnt; n = 0; got = 0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(posedge clock); n++;
      @(negedge clock);
      if (get_ack(who)) got = 1;
    end
    if (!got) chk("ack_timeout", 32'd0, 32'd1);
    else begin
      if (exp_lat >= 0) chk("latency", 32'(n), 32'(exp_lat));
      if (max_lat >= 0 && n > max_lat) chk("latency_bound", 32'(n), 32'(max_lat));
      if (exp_wr >= 0) chk("write_strobes", 32'(wr_cnt - w0), 32'(exp_wr));
    end
  endtask

  task automatic gap(input int who);
    release_req(who);
    @(negedge clock);
  endtask

  task automatic rand_proc(input int who, input int nops);
    bit          we;
    logic [3:0]  be;
    logic [31:0] a;
    int          r;
    for (int i = 0; i < nops; i++) begin
      we = 1'($urandom_range(0, 1));
      r  = $urandom_range(0, 3);
      be = (r == 0) ? 4'hF : (r == 1) ? 4'h0 : 4'($urandom_range(1, 14));
      a  = $urandom();
      a[11] = (who == 1);
      do_op(who, we, be, a, $urandom(), -1, 8, -1);
      if ($urandom_range(0, 2) != 0) begin
        release_req(who);
        repeat ($urandom_range(1, 3)) @(negedge clock);
      end
    end
    release_req(who);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    int mism;
    for (int i = 0; i < 1024; i++) ref_mem[i] = pat(i);
    repeat (3) @(negedge clock);
    chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("rst_ldr_ack", 32'(ldr_ack), 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_ldr_rdata", ldr_rdata, 32'd0);
    chk("rst_mem_write", 32'(dm_mem_write), 32'd0);
    chk("rst_address", dm_address, 32'd0);
    chk("rst_data_in", dm_data_in, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // read after reset, full write, partial write, be=0 write
    do_op(0, 0, 4'h0, 32'h10, 32'h0, 2, -1, 0);
    chk("rd_word4", cpu_rdata, 32'hDEADBEEF);
    gap(0);
    do_op(0, 1, 4'hF, 32'h20, 32'h12345678, 2, -1, 1);  gap(0);
    do_op(0, 0, 4'h0, 32'h20, 32'h0, 2, -1, 0);
    chk("rd_full_wr", cpu_rdata, 32'h12345678);
    gap(0);
    do_op(0, 1, 4'b0010, 32'h20, 32'h0000AB00, 3, -1, 1);  gap(0);
    do_op(0, 0, 4'h0, 32'h20, 32'h0, 2, -1, 0);
    chk("rd_partial_wr", cpu_rdata, 32'h1234AB78);
    gap(0);
    do_op(0, 1, 4'h0, 32'h20, 32'hFFFFFFFF, 2, -1, 0);  gap(0);
    do_op(0, 0, 4'h0, 32'h22, 32'h0, 2, -1, 0);
    chk("rd_be0_wr", cpu_rdata, 32'h1234AB78);
    gap(0);

    // fresh reset, then simultaneous requests held continuously
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    ack_order.delete();
    fork
      begin
        do_op(0, 0, 4'h0, 32'h100, 32'h0, 2, -1, -1);
        do_op(0, 0, 4'h0, 32'h104, 32'h0, -1, 8, -1);
        release_req(0);
      end
      begin
        do_op(1, 0, 4'h0, 32'h200, 32'h0, -1, 8, -1);
        do_op(1, 0, 4'h0, 32'h204, 32'h0, -1, 8, -1);
        release_req(1);
      end
    join
    @(negedge clock);
    chk("tie_ack_count", 32'(ack_order.size()), 32'd4);
    if (ack_order.size() == 4) begin
      chk("tie_order0", 32'(ack_order[0]), 32'd0);
      chk("tie_order1", 32'(ack_order[1]), 32'd1);
      chk("tie_order2", 32'(ack_order[2]), 32'd0);
      chk("tie_order3", 32'(ack_order[3]), 32'd1);
    end

    // 4 KB aliasing
    do_op(1, 1, 4'hF, 32'h1004, 32'hCAFEF00D, 2, -1, 1);  gap(1);
    do_op(0, 0, 4'h0, 32'h004, 32'h0, 2, -1, 0);
    chk("alias_rd", cpu_rdata, 32'hCAFEF00D);
    gap(0);

    // reset while a partial write sits in MERGE
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 4'b0101; cpu_addr = 32'h40; cpu_wdata = 32'hFFFFFFFF;
    @(posedge clock);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    cpu_req = 1'b0;
    #1;
    chk("abort_mem_write", 32'(dm_mem_write), 32'd0);
    chk("abort_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("abort_ldr_ack", 32'(ldr_ack), 32'd0);
    chk("abort_cpu_rdata", cpu_rdata, 32'd0);
    chk("abort_ldr_rdata", ldr_rdata, 32'd0);
    chk("abort_address", dm_address, 32'd0);
    chk("abort_data_in", dm_data_in, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    chk("abort_mem_word", mem[16], ref_mem[16]);
    @(negedge clock);
    do_op(0, 0, 4'h0, 32'h40, 32'h0, 2, -1, 0);
    gap(0);

    // randomized concurrent traffic, disjoint halves of memory per requester
    fork
      rand_proc(0, 40);
      rand_proc(1, 40);
    join
    repeat (6) @(negedge clock);
    chk("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
    chk("ldr_q_drained", 32'(ldr_q.size()), 32'd0);
    mism = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) mism++;
    chk("mem_final", 32'(mism), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
